// File: rtl/key_press_conditioner.sv
// Two-key press conditioner: 2-flop synchronizer per key, then either a debounce FSM
// (`KEY_DEBOUNCE_EN defined) or a plain registered press-edge detector (default build).
//
// state   | meaning
// IDLE    | key accepted as released, waiting for a pressed sample
// PEND_P  | press seen, counting stable pressed samples
// PRESSED | press accepted (pulse issued on entry), waiting for release
// PEND_R  | release seen, counting stable released samples; also the reset state
module key_press_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic Clock,
    input  logic RST,
    input  logic KEY_L_n,
    input  logic KEY_R_n,
    input  logic En,
    output logic L,
    output logic R
);

    logic [1:0] key_raw_n;
    logic [1:0] pulse;

    assign key_raw_n = {KEY_R_n, KEY_L_n};
    assign L = pulse[0];
    assign R = pulse[1];

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_debounce
        $error("key_press_conditioner: DEBOUNCE_CYCLES out of range 1..2^20");
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PEND_P,
        PRESSED,
        PEND_R
    } state_e;
`endif

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic sync1_q;
        logic sync2_q;
        logic pressed_s;
        logic pulse_q;
        logic pulse_d;

        // Synchronizer resets to "released" so a key held through reset reads as a new press later.
        always_ff @(posedge Clock or negedge RST) begin
            if (!RST) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
            end else begin
                sync1_q <= key_raw_n[gi];
                sync2_q <= sync1_q;
            end
        end

        assign pressed_s = ~sync2_q;
        assign pulse[gi] = pulse_q;

`ifdef KEY_DEBOUNCE_EN
        state_e        state_q;
        state_e        state_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        always_ff @(posedge Clock or negedge RST) begin
            if (!RST) begin
                state_q <= PEND_R;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pulse_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (pressed_s) begin
                        state_d = PEND_P;
                        cnt_d   = '0;
                    end
                end
                PEND_P: begin
                    if (!pressed_s) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        // En only gates this one entry; a suppressed pulse is never replayed.
                        state_d = PRESSED;
                        cnt_d   = '0;
                        pulse_d = En;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!pressed_s) begin
                        state_d = PEND_R;
                        cnt_d   = '0;
                    end
                end
                PEND_R: begin
                    if (pressed_s) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
`else
        logic prev_q;
        logic prev_d;

        always_ff @(posedge Clock or negedge RST) begin
            if (!RST) begin
                prev_q  <= 1'b1;
                pulse_q <= 1'b0;
            end else begin
                prev_q  <= prev_d;
                pulse_q <= pulse_d;
            end
        end

        always_comb begin
            prev_d  = pressed_s;
            pulse_d = pressed_s & ~prev_q & En;
        end
`endif
    end

endmodule

// File: tb/tb_key_press_conditioner.sv
// Self-checking bench for key_press_conditioner: directed scenarios plus random bouncing keys,
// checked every cycle against a run-length reference model; adapts to `KEY_DEBOUNCE_EN.
module tb_key_press_conditioner;

    localparam int D = 4;
`ifdef KEY_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif
    localparam int LAT = DB_EN ? D + 2 : 2;

    logic Clock   = 1'b0;
    logic RST     = 1'b0;
    logic KEY_L_n = 1'b1;
    logic KEY_R_n = 1'b1;
    logic En      = 1'b1;
    logic L;
    logic R;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    int l_cnt = 0, r_cnt = 0, l_first = 0, r_first = 0;

    // reference model: synchronizer delay line, accepted level and run of disagreeing samples
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_acc [2];
    int m_run [2];
    bit m_prev [2];
    bit m_pulse [2];

    key_press_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .Clock   (Clock),
        .RST     (RST),
        .KEY_L_n (KEY_L_n),
        .KEY_R_n (KEY_R_n),
        .En      (En),
        .L       (L),
        .R       (R)
    );

    initial forever #10 Clock = ~Clock;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d: observed=%b expected=%b", tag, edge_n, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            m_s1[ch] = 1'b1;
            m_s2[ch] = 1'b1;
            m_acc[ch] = 1'b1;
            m_run[ch] = 1;
            m_prev[ch] = 1'b1;
            m_pulse[ch] = 1'b0;
        end
    endtask

    // A level change is accepted after D+1 consecutive samples that disagree with the accepted level.
    task automatic model_edge();
        bit raw [2];
        bit p;
        raw[0] = KEY_L_n;
        raw[1] = KEY_R_n;
        for (int ch = 0; ch < 2; ch++) begin
            p = !m_s2[ch];
            m_s2[ch] = m_s1[ch];
            m_s1[ch] = raw[ch];
            m_pulse[ch] = 1'b0;
            if (DB_EN) begin
                if (p != m_acc[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == D + 1) begin
                        m_acc[ch] = p;
                        m_run[ch] = 0;
                        m_pulse[ch] = p && (En === 1'b1);
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end else begin
                m_pulse[ch] = p && !m_prev[ch] && (En === 1'b1);
                m_prev[ch] = p;
            end
        end
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #1;
        check_bit("rst_L", L, 1'b0);
        check_bit("rst_R", R, 1'b0);
        model_reset();
        repeat (2) @(negedge Clock);
        RST = 1'b1;
        edge_n = 0;
        l_cnt = 0;
        r_cnt = 0;
        l_first = 0;
        r_first = 0;
    endtask

    task automatic step(input logic kl, input logic kr, input logic en);
        KEY_L_n = kl;
        KEY_R_n = kr;
        En = en;
        @(posedge Clock);
        edge_n++;
        model_edge();
        @(negedge Clock);
        check_bit("L", L, m_pulse[0]);
        check_bit("R", R, m_pulse[1]);
        if (L === 1'b1) begin
            l_cnt++;
            if (l_first == 0) l_first = edge_n;
        end
        if (R === 1'b1) begin
            r_cnt++;
            if (r_first == 0) r_first = edge_n;
        end
    endtask

    initial begin
        int rem_l, rem_r;
        logic lvl_l, lvl_r, en_r;

        @(negedge Clock);

        // clean left press
        do_reset();
        for (int e = 1; e <= 40; e++) step((e >= 10 && e < 30) ? 1'b0 : 1'b1, 1'b1, 1'b1);
        check_int("clean_L_count", l_cnt, 1);
        check_int("clean_L_edge", l_first, 10 + LAT);
        check_int("clean_R_count", r_cnt, 0);

        // right key bouncing in 2-cycle halves
        do_reset();
        for (int e = 1; e <= 30; e++)
            step(1'b1, (e >= 10 && e < 22) ? (((e - 10) / 2) % 2 == 1) : 1'b1, 1'b1);
        check_int("bounce_R_count", r_cnt, DB_EN ? 0 : 3);
        check_int("bounce_L_count", l_cnt, 0);

        // simultaneous presses
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            step((e >= 10 && e < 30) ? 1'b0 : 1'b1, (e >= 10 && e < 30) ? 1'b0 : 1'b1, 1'b1);
        end
        check_int("both_L_edge", l_first, 10 + LAT);
        check_int("both_R_edge", r_first, 10 + LAT);
        check_int("both_L_count", l_cnt, 1);
        check_int("both_R_count", r_cnt, 1);

        // key held through reset release, released, pressed again
        KEY_L_n = 1'b0;
        do_reset();
        for (int e = 1; e <= 55; e++)
            step((e <= 15 || (e >= 26 && e <= 45)) ? 1'b0 : 1'b1, 1'b1, 1'b1);
        check_int("held_rst_L_count", l_cnt, DB_EN ? 1 : 2);
        check_int("held_rst_L_edge", l_first, DB_EN ? 26 + LAT : 3);

        // En low across press acceptance, raised while still held
        do_reset();
        for (int e = 1; e <= 40; e++) step((e >= 10 && e <= 30) ? 1'b0 : 1'b1, 1'b1, (e <= 20) ? 1'b0 : 1'b1);
        check_int("en_low_L_count", l_cnt, 0);

        // reset shortly after a press starts, key still held afterwards
        do_reset();
        for (int e = 1; e <= 12; e++) step((e >= 10) ? 1'b0 : 1'b1, 1'b1, 1'b1);
        do_reset();
        for (int e = 1; e <= 30; e++) step((e <= 20) ? 1'b0 : 1'b1, 1'b1, 1'b1);
        check_int("rst_mid_L_count", l_cnt, DB_EN ? 0 : 1);

        // reset while the pulse is high
        do_reset();
        for (int e = 1; e <= 10 + LAT; e++) step((e >= 10) ? 1'b0 : 1'b1, 1'b1, 1'b1);
        check_int("pulse_before_rst", l_cnt, 1);
        do_reset();
        for (int e = 1; e <= 15; e++) step(1'b1, 1'b1, 1'b1);
        check_int("pulse_after_rst", l_cnt, 0);

        // random bouncing keys with occasional enable drops and resets
        do_reset();
        rem_l = 0;
        rem_r = 0;
        lvl_l = 1'b1;
        lvl_r = 1'b1;
        for (int i = 0; i < 900; i++) begin
            if (i == 300 || i == 620) do_reset();
            if (rem_l == 0) begin
                lvl_l = 1'($urandom_range(0, 1));
                rem_l = $urandom_range(1, 12);
            end
            if (rem_r == 0) begin
                lvl_r = 1'($urandom_range(0, 1));
                rem_r = $urandom_range(1, 12);
            end
            en_r = ($urandom_range(0, 7) != 0);
            step(lvl_l, lvl_r, en_r);
            rem_l--;
            rem_r--;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_press_conditioner.md
KEY_PRESS_CONDITIONER -- requirements
Module: key_press_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, stable-sample count required to accept a press or release; legal range 1..2^20.
REQ-002 Port: Clock  input  1  system clock, 50 MHz on board; all state on its rising edge.
REQ-003 Port: RST  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: KEY_L_n  input  1  raw left push-button, active-low, asynchronous to Clock, may bounce.
REQ-005 Port: KEY_R_n  input  1  raw right push-button, active-low, asynchronous to Clock, may bounce.
REQ-006 Port: En  input  1  pulse enable; 0 suppresses L/R pulses, tracking continues.
REQ-007 Port: L  output  1  one-cycle press pulse, left; drives the L input of the playfield light cells.
REQ-008 Port: R  output  1  one-cycle press pulse, right; drives the R input of the playfield light cells.

Function
REQ-009 Each key SHALL have an independent, identical channel; no shared state except Clock/RST/En.
REQ-010 Each channel SHALL pass its raw key through a 2-flop synchronizer; pressed_s = NOT sync2.
REQ-011 Let edge k be the first rising edge sampling raw key low; pressed_s SHALL first be 1 in the cycle after edge k+1.
REQ-012 Debounce FSM states: IDLE, PEND_P, PRESSED, PEND_R; counter width clog2(DEBOUNCE_CYCLES+1) bits.
REQ-013 IDLE: pressed_s=1 -> PEND_P, cnt<=0; else stay.
REQ-014 PEND_P: pressed_s=0 -> IDLE, cnt<=0; pressed_s=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED with pulse; else cnt<=cnt+1.
REQ-015 PRESSED: pressed_s=0 -> PEND_R, cnt<=0; else stay; no pulse while held.
REQ-016 PEND_R: pressed_s=1 -> PRESSED, no pulse; pressed_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt<=cnt+1.
REQ-017 Pulse output SHALL be registered: set at the edge of the PEND_P->PRESSED transition, cleared at the next edge; width exactly 1 cycle.
REQ-018 Press latency: clean press at edge k SHALL give pulse high from edge k+2+DEBOUNCE_CYCLES to k+3+DEBOUNCE_CYCLES.
REQ-019 Bounce shorter than DEBOUNCE_CYCLES stable samples SHALL produce no pulse and no extra pulse on release.
REQ-020 A held key SHALL produce exactly one pulse regardless of hold length; a new pulse requires reaching IDLE first.
REQ-021 En=0 at the PRESSED-entry edge SHALL suppress that pulse permanently (no deferred pulse); FSM still enters PRESSED.
REQ-022 Simultaneous qualified presses SHALL assert L and R in the same cycle; no arbitration.
REQ-023 Counter SHALL never exceed DEBOUNCE_CYCLES-1; no wrap.

Reset
REQ-024 RST=0 SHALL immediately force: sync flops to 1 (released), FSM to PEND_R, cnt to 0, L=0, R=0.
REQ-025 Reset into PEND_R SHALL make a key held through reset release produce no pulse until released and re-pressed.
REQ-026 RST asserted mid-debounce or mid-pulse SHALL abort it with L/R low in the same cycle; no pulse after release of RST for that press.

Configuration
REQ-027 Macro KEY_DEBOUNCE_EN defined: debounce FSM per REQ-012..REQ-021 compiled in.
REQ-028 KEY_DEBOUNCE_EN undefined: FSM and counter removed; pulse = pressed_s AND NOT prev AND En, registered; prev resets to 1; press latency edge k+2 to k+3; DEBOUNCE_CYCLES ignored.
REQ-029 Both builds SHALL have identical ports and reset values of L/R.

Verification (DEBOUNCE_CYCLES=4, KEY_DEBOUNCE_EN defined unless stated)
REQ-030 KEY_L_n low from edge 10 for 20 cycles, En=1 -> L high exactly cycle 16-17, R stays 0.
REQ-031 KEY_R_n toggles low/high every 2 cycles for 12 cycles then high -> R never asserts.
REQ-032 Both keys low at edge 10, En=1 -> L and R high together, edges 16-17.
REQ-033 KEY_L_n held low across RST release, released 10 cycles, pressed again -> no pulse for first hold, one pulse on second.
REQ-034 En=0 during PRESSED entry, then En=1 while still held -> no L pulse; RST=0 mid PEND_P -> L=0 and no pulse after reset.
REQ-035 KEY_DEBOUNCE_EN undefined, KEY_L_n low at edge 10 -> L high edges 12-13, single pulse while held.
